// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter with registered one-hot grant.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_n #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    wbm_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    wbm_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    wbm_dat_o,
  input  logic [NUM_MASTERS-1:0]               wbm_we_i,
  input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]               wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]               wbm_cyc_i,
  output logic [NUM_MASTERS-1:0]               wbm_ack_o,
  output logic [NUM_MASTERS-1:0]               wbm_err_o,
  output logic [ADDR_WIDTH-1:0]                wbs_adr_o,
  output logic [DATA_WIDTH-1:0]                wbs_dat_o,
  output logic                                 wbs_we_o,
  output logic [SELECT_WIDTH-1:0]              wbs_sel_o,
  output logic                                 wbs_stb_o,
  output logic                                 wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]                wbs_dat_i,
  input  logic                                 wbs_ack_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 grant_valid_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {StIdle, StOwned} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        last_owner_q, last_owner_d;

  logic                   grant_valid;
  logic                   grant_chg;
  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  logic                   abort;

  assign grant_valid   = (state_q == StOwned);
  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid;

  // Winner search over current requests; the owner (if any) is always
  // last_owner_q, so rotation naturally visits it last.
  always_comb begin
    int unsigned start;
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    start     = 32'(last_owner_q) + 32'd1;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (ROUND_ROBIN != 0) begin
        cand = (start + i) % NUM_MASTERS;
      end else begin
        cand = i;
      end
      if (!win_found && wbm_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StOwned;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_owner_d     = win_idx;
        end
      end
      StOwned: begin
        // Owner's cyc is low here, so it cannot win its own re-arbitration.
        if (!wbm_cyc_i[last_owner_q]) begin
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            last_owner_d     = win_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  assign grant_chg = (state_d != state_q) || (grant_d != grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_owner_q <= IdxW'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    if (grant_valid) begin
      wbs_adr_o = wbm_adr_i[32'(last_owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
      wbs_dat_o = wbm_dat_i[32'(last_owner_q)*DATA_WIDTH +: DATA_WIDTH];
      wbs_we_o  = wbm_we_i[last_owner_q];
      wbs_sel_o = wbm_sel_i[32'(last_owner_q)*SELECT_WIDTH +: SELECT_WIDTH];
      wbs_cyc_o = wbm_cyc_i[last_owner_q] & ~abort;
      wbs_stb_o = wbs_cyc_o & wbm_stb_i[last_owner_q];
    end
  end

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = {NUM_MASTERS{wbs_ack_i & grant_valid & ~abort}} & grant_q & wbm_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  // Abort is decoded from the registered count, so it lasts exactly one cycle.
  assign abort     = grant_valid && (wd_cnt_q == CntW'(TIMEOUT_CYCLES));
  assign wbm_err_o = abort ? grant_q : '0;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (abort || grant_chg || !wbs_stb_o || wbs_ack_i) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign wbm_err_o      = '0;
  assign unused_timeout = grant_chg ^ (TIMEOUT_CYCLES != 0);
`endif

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o));
  a_valid_match  : assert property (@(posedge clk) disable iff (rst)
                                    grant_valid_o == (|grant_o));

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: round-robin and fixed-priority instances share stimulus.
module tb_wb_arbiter_n;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N-1:0]    we  = '0;
  logic [N*SW-1:0] sel = '0;
  logic [N-1:0]    stb = '0;
  logic [N-1:0]    cyc = '0;
  logic [DW-1:0]   s_dat = '0;
  logic            s_ack = 1'b0;

  logic [N*DW-1:0] rr_mdat;
  logic [N-1:0]    rr_ack, rr_err, rr_grant;
  logic [AW-1:0]   rr_adr;
  logic [DW-1:0]   rr_dat;
  logic            rr_we, rr_stb, rr_cyc, rr_valid;
  logic [SW-1:0]   rr_sel;

  logic [N*DW-1:0] fp_mdat;
  logic [N-1:0]    fp_ack, fp_err, fp_grant;
  logic [AW-1:0]   fp_adr;
  logic [DW-1:0]   fp_dat;
  logic            fp_we, fp_stb, fp_cyc, fp_valid;
  logic [SW-1:0]   fp_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_n #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                 .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_dat_o(rr_mdat),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(rr_ack), .wbm_err_o(rr_err), .wbs_adr_o(rr_adr), .wbs_dat_o(rr_dat),
    .wbs_we_o(rr_we), .wbs_sel_o(rr_sel), .wbs_stb_o(rr_stb), .wbs_cyc_o(rr_cyc),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .grant_o(rr_grant), .grant_valid_o(rr_valid)
  );

  wb_arbiter_n #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                 .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_dat_o(fp_mdat),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(fp_ack), .wbm_err_o(fp_err), .wbs_adr_o(fp_adr), .wbs_dat_o(fp_dat),
    .wbs_we_o(fp_we), .wbs_sel_o(fp_sel), .wbs_stb_o(fp_stb), .wbs_cyc_o(fp_cyc),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .grant_o(fp_grant), .grant_valid_o(fp_valid)
  );

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc   = '0;
    stb   = '0;
    s_ack = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    s_dat = 32'hA5A5_5A5A;
    #1;
    checks++; if (rr_grant !== 4'b0000) begin failures++;
      $display("FAIL reset_grant got=%b exp=0000", rr_grant); end
    checks++; if (rr_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", rr_valid); end
    checks++; if ({rr_cyc, rr_stb, rr_ack, rr_err} !== 10'd0) begin failures++;
      $display("FAIL reset_outs got=%b exp=0", {rr_cyc, rr_stb, rr_ack, rr_err}); end
    checks++; if (rr_mdat !== {4{32'hA5A5_5A5A}}) begin failures++;
      $display("FAIL reset_broadcast got=%h exp=%h", rr_mdat, {4{32'hA5A5_5A5A}}); end
  endtask

  task automatic test_round_robin();
    int unsigned exp_idx;
    logic [N-1:0] exp_g;
    do_reset();
    for (int k = 0; k < N; k++) adr[k*AW +: AW] = 32'h100 * (k + 1);
    cyc = 4'b1111;
    stb = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_idx = k % N;
      exp_g   = 4'b0001 << exp_idx;
      checks++; if (rr_grant !== exp_g || rr_cyc !== 1'b1) begin failures++;
        $display("FAIL rr_grant_%0d got=%b/%b exp=%b/1", k, rr_grant, rr_cyc, exp_g); end
      checks++; if (rr_adr !== 32'h100 * (exp_idx + 1)) begin failures++;
        $display("FAIL rr_adr_%0d got=%h exp=%h", k, rr_adr, 32'h100 * (exp_idx + 1)); end
      s_ack = 1'b1;
      #1;
      checks++; if (rr_ack !== exp_g) begin failures++;
        $display("FAIL rr_ack_%0d got=%b exp=%b", k, rr_ack, exp_g); end
      step();
      s_ack = 1'b0;
      cyc[exp_idx] = 1'b0;
      #1;
      checks++; if (rr_cyc !== 1'b0 || rr_grant !== exp_g) begin failures++;
        $display("FAIL rr_gap_%0d got=%b/%b exp=0/%b", k, rr_cyc, rr_grant, exp_g); end
      step();
      cyc[exp_idx] = 1'b1;
      #1;
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    cyc = 4'b1010;
    stb = 4'b1010;
    #1;
    checks++; if (fp_valid !== 1'b0) begin failures++;
      $display("FAIL fp_pre_grant got=%b exp=0", fp_valid); end
    step();
    checks++; if (fp_grant !== 4'b0010 || fp_cyc !== 1'b1) begin failures++;
      $display("FAIL fp_first got=%b/%b exp=0010/1", fp_grant, fp_cyc); end
    step();
    checks++; if (fp_grant !== 4'b0010) begin failures++;
      $display("FAIL fp_hold got=%b exp=0010", fp_grant); end
    cyc[1] = 1'b0;
    step();
    checks++; if (fp_grant !== 4'b1000 || fp_cyc !== 1'b1) begin failures++;
      $display("FAIL fp_second got=%b/%b exp=1000/1", fp_grant, fp_cyc); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    cyc = 4'b0100;
    stb = 4'b0100;
    step();
    checks++; if (rr_grant !== 4'b0100) begin failures++;
      $display("FAIL np_grant got=%b exp=0100", rr_grant); end
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    step();
    checks++; if (rr_grant !== 4'b0100) begin failures++;
      $display("FAIL np_hold got=%b exp=0100", rr_grant); end
    s_ack = 1'b1;
    #1;
    checks++; if (rr_ack !== 4'b0100) begin failures++;
      $display("FAIL np_ack got=%b exp=0100", rr_ack); end
    step();
    s_ack  = 1'b0;
    cyc[2] = 1'b0;
    step();
    checks++; if (rr_grant !== 4'b0001) begin failures++;
      $display("FAIL np_handover got=%b exp=0001", rr_grant); end
  endtask

  task automatic test_write_passthrough();
    do_reset();
    adr[1*AW +: AW] = 32'h1000_0040;
    dat[1*DW +: DW] = 32'hDEAD_BEEF;
    sel[1*SW +: SW] = 4'hF;
    we[1]  = 1'b1;
    stb[1] = 1'b1;
    cyc[1] = 1'b1;
    step();
    checks++; if (rr_adr !== 32'h1000_0040 || rr_dat !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL wr_adr_dat got=%h/%h exp=10000040/deadbeef", rr_adr, rr_dat); end
    checks++; if ({rr_sel, rr_we, rr_stb, rr_cyc} !== 7'b1111_111) begin failures++;
      $display("FAIL wr_ctrl got=%b exp=1111111", {rr_sel, rr_we, rr_stb, rr_cyc}); end
    checks++; if (rr_ack !== 4'b0000) begin failures++;
      $display("FAIL wr_noack got=%b exp=0000", rr_ack); end
    s_ack = 1'b1;
    s_dat = 32'h1234_5678;
    #1;
    checks++; if (rr_ack !== 4'b0010) begin failures++;
      $display("FAIL wr_ack got=%b exp=0010", rr_ack); end
    checks++; if (rr_mdat[1*DW +: DW] !== 32'h1234_5678) begin failures++;
      $display("FAIL wr_rdata got=%h exp=12345678", rr_mdat[1*DW +: DW]); end
    step();
    s_ack = 1'b0;
    #1;
    checks++; if (rr_ack !== 4'b0000) begin failures++;
      $display("FAIL wr_ack_drop got=%b exp=0000", rr_ack); end
    we = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    cyc = 4'b0001;
    stb = 4'b0001;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (rr_stb !== 1'b1 || rr_err !== 4'b0000) begin failures++;
        $display("FAIL to_stall_%0d got=%b/%b exp=1/0000", i, rr_stb, rr_err); end
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    checks++; if (rr_err !== 4'b0001 || rr_cyc !== 1'b0 || rr_stb !== 1'b0) begin failures++;
      $display("FAIL to_abort got=%b/%b/%b exp=0001/0/0", rr_err, rr_cyc, rr_stb); end
    s_ack = 1'b1;
    #1;
    checks++; if (rr_ack !== 4'b0000) begin failures++;
      $display("FAIL to_ack_mask got=%b exp=0000", rr_ack); end
    s_ack = 1'b0;
    step();
    checks++; if (rr_err !== 4'b0000 || rr_cyc !== 1'b1 || rr_grant !== 4'b0001) begin
      failures++;
      $display("FAIL to_after got=%b/%b/%b exp=0000/1/0001", rr_err, rr_cyc, rr_grant); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (rr_err !== 4'b0000 || rr_stb !== 1'b1) begin failures++;
        $display("FAIL to_persist_%0d got=%b/%b exp=0000/1", i, rr_err, rr_stb); end
      step();
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc = 4'b0010;
    stb = 4'b0010;
    step();
    checks++; if (rr_grant !== 4'b0010) begin failures++;
      $display("FAIL rm_owner got=%b exp=0010", rr_grant); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 4'b0101;
    stb = 4'b0101;
    #1;
    checks++; if (rr_grant !== 4'b0000 || rr_valid !== 1'b0 || rr_cyc !== 1'b0) begin
      failures++;
      $display("FAIL rm_clear got=%b/%b/%b exp=0000/0/0", rr_grant, rr_valid, rr_cyc); end
    step();
    checks++; if (rr_grant !== 4'b0001 || rr_valid !== 1'b1) begin failures++;
      $display("FAIL rm_regrant got=%b/%b exp=0001/1", rr_grant, rr_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_no_preempt();
    test_write_passthrough();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised N-master to 1-slave Wishbone classic arbiter. It sits between the core, debug, DMA and other bus masters and a single shared slave port, typically the interconnect or memory bus. A master keeps the grant for as long as it holds CYC. Arbitration is round-robin or fixed-priority, with registered grant state. An optional bus watchdog aborts transfers that the slave never acknowledges and signals an error to the owning master.

## Interface
Parameters:
- NUM_MASTERS, 4: number of master ports, 2..16.
- DATA_WIDTH, 32: data bus width (8/16/32/64).
- ADDR_WIDTH, 32: address bus width.
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- ROUND_ROBIN, 1: 1 = round-robin; 0 = fixed priority, where the lowest index wins.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles, ≥2. Used only with WB_ARB_TIMEOUT_EN.

Ports (all flattened vectors use master k at slice [k*W +: W]):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses.
- wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data.
- wbm_dat_o  out  NUM_MASTERS*DATA_WIDTH  wbs_dat_i replicated to every master.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_sel_i  in  NUM_MASTERS*SELECT_WIDTH  byte selects.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cyc_i  in  NUM_MASTERS  cycle / bus request.
- wbm_ack_o  out  NUM_MASTERS  acknowledge to the owner only.
- wbm_err_o  out  NUM_MASTERS  timeout error pulse to the owner.
- wbs_adr_o / wbs_dat_o / wbs_we_o / wbs_sel_o / wbs_stb_o / wbs_cyc_o  out  ADDR_WIDTH / DATA_WIDTH / 1 / SELECT_WIDTH / 1 / 1  slave request.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- wbs_ack_i  in  1  slave acknowledge.
- grant_o  out  NUM_MASTERS  registered one-hot grant.
- grant_valid_o  out  1  grant_o holds a valid owner.

## Operation
- Registered state:
  - grant (one-hot).
  - grant_valid.
  - last_owner, an index.
  - watchdog counter, $clog2(TIMEOUT_CYCLES+1) bits.
- Two states: IDLE (grant_valid=0) and OWNED (grant_valid=1).
- IDLE: on any wbm_cyc_i high, the next edge latches the winner into grant and sets grant_valid.
- Round-robin search starts at (last_owner+1) mod NUM_MASTERS, wrapping; the winner's index is written to last_owner.
- Fixed-priority mode: the lowest asserted index wins, and last_owner is ignored.
- OWNED: the grant is held while wbm_cyc_i[owner]=1. Other requests are ignored, so there is no preemption.
- Release: at the edge where wbm_cyc_i[owner]=0, re-arbitration runs over the current requests (excluding the old owner in round-robin mode, which the rotation already does).
  - If a winner exists, it is granted at that same edge; the handover has no idle cycle.
  - Otherwise the block goes to IDLE.
- Slave outputs are a combinational mux of the owner's signals, forced to all-zero when grant_valid=0:
  - wbs_cyc_o = grant_valid & wbm_cyc_i[owner].
  - wbs_stb_o = wbs_cyc_o & wbm_stb_i[owner].
- wbm_ack_o[k] = wbs_ack_i & grant[k] & grant_valid & wbm_cyc_i[k]. Non-owners never see ack or err.
- Reset (including mid-transfer): at the edge with rst=1, the block clears grant, grant_valid, counter and error state, and sets last_owner=NUM_MASTERS-1 so master 0 has first priority. All outputs are then 0 apart from the wbm_dat_o broadcast.

## Timing
- Request-to-grant latency: 1 cycle. If cyc rises before edge t, grant_o and wbs_cyc_o are valid after edge t.
- A master must not expect ack in the cycle its cyc first rises.
- Ack path wbs_ack_i → wbm_ack_o is combinational (0 cycles). Read data passes straight through.
- Back-to-back handover: with the owner's cyc low before edge t and another request present, the new owner drives the slave after edge t. wbs_cyc_o is low for exactly that one cycle before edge t.
- Simultaneous requests from all masters in round-robin mode are granted in the rotating order 0,1,2,…,N-1,0, each grant lasting until that master drops cyc.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - The counter increments each cycle that wbs_stb_o=1 and wbs_ack_i=0.
  - It clears on ack, on stb low, or on a grant change.
  - When the counter equals TIMEOUT_CYCLES, the next cycle is an abort cycle:
    - wbm_err_o[owner]=1 for exactly one cycle.
    - wbs_cyc_o and wbs_stb_o are forced to 0.
    - wbm_ack_o is masked.
    - The counter clears.
  - The grant is retained; the master decides whether to drop cyc.
- WB_ARB_TIMEOUT_EN undefined: no counter logic; wbm_err_o is tied to 0; TIMEOUT_CYCLES is unused.

## Test plan
- NUM_MASTERS=4, ROUND_ROBIN=1, all cyc high, each master drops cyc after ack → grants in order 0,1,2,3,0. Each handover is at the release edge, with wbs_cyc_o low for one cycle.
- ROUND_ROBIN=0, masters 1 and 3 request at the same time → master 1 granted after 1 edge. Master 3 is granted at the edge where master 1's cyc drops.
- Master 2 owns the bus, master 0 raises cyc mid-transfer → no preemption; wbm_ack_o[0] stays 0 while wbs_ack_i pulses.
- Master 1 writes adr=0x1000_0040, dat=0xDEADBEEF, sel=4'hF → the slave sees identical values; wbs_ack_i pulse → wbm_ack_o[1]=1 in the same cycle only.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks → 8 stalled cycles, then wbm_err_o[owner]=1 for 1 cycle with wbs_cyc_o=0. Without the macro, no err and the stall persists.
- rst asserted mid-transfer → after that edge grant_o=0, grant_valid_o=0 and wbs_cyc_o=0. The next request from masters 0 and 2 together grants master 0.
